// File: rtl/v_sv_arb_pkg.sv
// Shared types and the round-robin selection helper for the burst-locked arbiter.
package v_sv_arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  localparam int MAX_NREQ = 16;
  localparam int PTRW_MAX = 4;

  function automatic int idw(input int nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

  localparam int IDW_DEF = idw(4);

  // Lowest set bit at or above ptr; if none, lowest set bit overall (wrap-around).
  function automatic logic [MAX_NREQ-1:0] rr_pick(input logic [MAX_NREQ-1:0] req,
                                                  input logic [PTRW_MAX-1:0] ptr);
    logic [MAX_NREQ-1:0] masked;
    logic [MAX_NREQ-1:0] oh;
    masked = req & ~((16'd1 << ptr) - 16'd1);
    if (masked != 16'd0) begin
      oh = masked & (~masked + 16'd1);
    end else begin
      oh = req & (~req + 16'd1);
    end
    return oh;
  endfunction

endpackage

// File: rtl/v_sv_rr_pick.sv
// Masked round-robin priority encoder: one-hot winner plus its binary index.
module v_sv_rr_pick
  import v_sv_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] grant_oh_o,
  output logic [IDW-1:0]  grant_idx_o
);

  logic [MAX_NREQ-1:0] req_ext_s;
  logic [MAX_NREQ-1:0] pick_full_s;

  // Widen to the helper's fixed width; bits above NREQ stay zero so never win.
  always_comb begin
    req_ext_s = {MAX_NREQ{1'b0}};
    req_ext_s[NREQ-1:0] = req_i;
    pick_full_s = rr_pick(req_ext_s, PTRW_MAX'(ptr_i));
    grant_oh_o = pick_full_s[NREQ-1:0];
    grant_idx_o = {IDW{1'b0}};
    for (int i = 0; i < MAX_NREQ; i++) begin
      if (pick_full_s[i]) begin
        grant_idx_o = grant_idx_o | IDW'(i);
      end else begin
        grant_idx_o = grant_idx_o;
      end
    end
  end

endmodule

// File: rtl/v_sv_rr_arb.sv
// Burst-locked round-robin arbiter sharing one sink among NREQ requesters,
// with an optional per-grant beat limit that forces release.
module v_sv_rr_arb
  import v_sv_arb_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int DW        = 32,
  parameter int MAX_BEATS = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*DW-1:0]      req_data,
  input  logic [NREQ-1:0]         req_last,
  output logic [NREQ-1:0]         req_ready,
  output logic                    snk_valid,
  output logic [DW-1:0]           snk_data,
  output logic                    snk_last,
  output logic [$clog2(NREQ)-1:0] snk_id,
  input  logic                    snk_ready,
  output logic [NREQ-1:0]         grant_oh,
  output logic                    forced_rel
);

  localparam int IDW = idw(NREQ);
  localparam int CW  = (MAX_BEATS > 1) ? $clog2(MAX_BEATS + 1) : 1;
  localparam logic [CW-1:0] CNT_SAT = (MAX_BEATS != 0) ? CW'(MAX_BEATS) : {CW{1'b1}};

  arb_state_e       state_q;
  logic [NREQ-1:0]  grant_oh_q;
  logic [IDW-1:0]   snk_id_q;
  logic [IDW-1:0]   rr_ptr_q;
  logic [IDW-1:0]   rr_ptr_d;
  logic [CW-1:0]    beat_cnt_q;
  logic [CW-1:0]    beat_cnt_d;
  logic             forced_rel_q;

  logic [NREQ-1:0]  pick_oh_s;
  logic [IDW-1:0]   pick_idx_s;
  logic             busy_s;
  logic             limit_hit_s;
  logic             xfer_s;
  logic             release_s;

  v_sv_rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .req_i       (req_valid),
    .ptr_i       (rr_ptr_q),
    .grant_oh_o  (pick_oh_s),
    .grant_idx_o (pick_idx_s)
  );

  generate
    if (MAX_BEATS != 0) begin : g_limit
      assign limit_hit_s = (beat_cnt_q == CW'(MAX_BEATS - 1));
    end else begin : g_nolimit
      assign limit_hit_s = 1'b0;
    end
  endgenerate

  assign busy_s = (state_q == BUSY);

  // Sink side is a straight pass-through of the locked requester while busy.
  always_comb begin
    snk_valid = 1'b0;
    snk_data  = {DW{1'b0}};
    snk_last  = 1'b0;
    req_ready = {NREQ{1'b0}};
    if (busy_s) begin
      snk_valid           = req_valid[snk_id_q];
      snk_data            = req_data[int'(snk_id_q)*DW +: DW];
      snk_last            = req_last[snk_id_q] | limit_hit_s;
      req_ready[snk_id_q] = snk_ready;
    end else begin
      snk_valid = 1'b0;
    end
  end

  assign xfer_s    = busy_s & snk_valid & snk_ready;
  assign release_s = xfer_s & (req_last[snk_id_q] | limit_hit_s);

  // Next beat count (saturating) and next round-robin pointer.
  always_comb begin
    if (xfer_s && (beat_cnt_q != CNT_SAT)) begin
      beat_cnt_d = beat_cnt_q + CW'(1'b1);
    end else begin
      beat_cnt_d = beat_cnt_q;
    end
    if (snk_id_q == IDW'(NREQ - 1)) begin
      rr_ptr_d = {IDW{1'b0}};
    end else begin
      rr_ptr_d = snk_id_q + IDW'(1'b1);
    end
  end

  // Grant FSM: arbitrate in IDLE, hold the grant in BUSY until last or limit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_oh_q   <= {NREQ{1'b0}};
      snk_id_q     <= {IDW{1'b0}};
      rr_ptr_q     <= {IDW{1'b0}};
      beat_cnt_q   <= {CW{1'b0}};
      forced_rel_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          forced_rel_q <= 1'b0;
          if (|req_valid) begin
            state_q    <= BUSY;
            grant_oh_q <= pick_oh_s;
            snk_id_q   <= pick_idx_s;
            beat_cnt_q <= {CW{1'b0}};
          end else begin
            state_q    <= IDLE;
            grant_oh_q <= {NREQ{1'b0}};
          end
        end
        BUSY: begin
          beat_cnt_q <= beat_cnt_d;
          if (release_s) begin
            state_q      <= IDLE;
            grant_oh_q   <= {NREQ{1'b0}};
            rr_ptr_q     <= rr_ptr_d;
            forced_rel_q <= limit_hit_s & ~req_last[snk_id_q];
          end else begin
            state_q      <= BUSY;
            forced_rel_q <= 1'b0;
          end
        end
        default: begin
          state_q      <= IDLE;
          grant_oh_q   <= {NREQ{1'b0}};
          forced_rel_q <= 1'b0;
        end
      endcase
    end
  end

  assign grant_oh   = grant_oh_q;
  assign snk_id     = snk_id_q;
  assign forced_rel = forced_rel_q;

endmodule
